// File: rtl/exec_pkg.sv
// Shared types and constants for the picoMIPS run-control sequencer.
package exec_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } exec_state_t;

  localparam logic [2:0] HALT_OP_DEFAULT = 3'b111;

endpackage

// File: rtl/exec_ctrl_btn_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous pushbutton.
// A held button yields exactly one single-cycle pulse.
module btn_sync (
  input  logic clk,
  input  logic nreset,
  input  logic btn,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/exec_ctrl.sv
// Run-control sequencer for picoMIPS: gates execution via cpu_en and counts executed instructions.
// Optional breakpoint support is compiled in when BREAKPOINT_EN is defined.
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int         Psize   = 5,
  parameter int         CNTW    = 16,
  parameter logic [2:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic [Psize-1:0] pc_addr,
  input  logic [2:0]       opcode,
  input  logic [Psize-1:0] bp_addr,
  input  logic             bp_valid,
  output logic             cpu_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNTW-1:0]  instr_count
);

  exec_state_t st;
  logic        run_pulse;
  logic        step_pulse;
  logic        is_halt;
  logic        bp_stop;
  logic        stop;

  btn_sync u_run_sync (
    .clk    (clk),
    .nreset (nreset),
    .btn    (run_btn),
    .pulse  (run_pulse)
  );

  btn_sync u_step_sync (
    .clk    (clk),
    .nreset (nreset),
    .btn    (step_btn),
    .pulse  (step_pulse)
  );

  assign is_halt = (opcode == HALT_OP);

`ifdef BREAKPOINT_EN
  logic bp_skip;
  logic bp_hit;

  assign bp_hit  = bp_valid & (pc_addr == bp_addr);
  assign bp_stop = bp_hit & ~bp_skip;

  // Resuming from PAUSE lets the instruction sitting on the breakpoint execute once.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      bp_skip <= 1'b0;
    end else if (st == PAUSE && run_pulse) begin
      bp_skip <= 1'b1;
    end else if (st == RUN && cpu_en) begin
      bp_skip <= 1'b0;
    end
  end
`else
  logic unused_bp;

  assign unused_bp = ^{bp_valid, bp_addr, pc_addr};
  assign bp_stop   = 1'b0;
`endif

  assign stop  = halt_req | is_halt | bp_stop;
  assign state = st;

  always_comb begin
    cpu_en = 1'b0;
    case (st)
      RUN:     cpu_en = ~stop;
      STEP:    cpu_en = ~is_halt;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      st     <= IDLE;
      halted <= 1'b0;
    end else begin
      case (st)
        IDLE, PAUSE: begin
          if (run_pulse) begin
            st     <= RUN;
            halted <= 1'b0;
          end else if (step_pulse) begin
            st     <= STEP;
            halted <= 1'b0;
          end
        end
        RUN: begin
          if (is_halt) begin
            st     <= DONE;
            halted <= 1'b1;
          end else if (stop) begin
            st     <= PAUSE;
            halted <= 1'b1;
          end
        end
        // Single-step ignores pause requests and breakpoints; only HALT matters.
        STEP: begin
          st     <= is_halt ? DONE : PAUSE;
          halted <= 1'b1;
        end
        DONE: begin
          st     <= DONE;
          halted <= 1'b1;
        end
        default: begin
          st     <= IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      instr_count <= '0;
    end else if (cpu_en && (instr_count != {CNTW{1'b1}})) begin
      instr_count <= instr_count + 1'b1;
    end
  end

endmodule
